// File: rtl/fsm_trace_pkg.sv
// Shared types for the FSM trace monitor: control states, event record layout
// and the transition legality rule.
package fsm_trace_pkg;

   typedef enum logic {S_IDLE = 1'b0, S_TRACK = 1'b1} state_e;

   // Event record, MSB to LSB: {prev[W], next[W], dwell[CNT_W], illegal}
   localparam int OFF_ILL   = 0;
   localparam int OFF_DWELL = 1;

   function automatic int evt_w(int w, int c);
      return 2 * w + c + 1;
   endfunction

   function automatic int off_next(int c);
      return 1 + c;
   endfunction

   function automatic int off_prev(int w, int c);
      return 1 + c + w;
   endfunction

   // Legal: step to prev+1 (wrapping at 2^w) or return to the idle code 0.
   function automatic logic is_legal(logic [31:0] prev, logic [31:0] next, int w);
      logic [31:0] mask;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return ((next & mask) == ((prev + 32'd1) & mask)) || ((next & mask) == 32'd0);
   endfunction

endpackage

// File: rtl/fsm_trace_fifo.sv
// Generic synchronous show-ahead FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module fsm_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr_en, rd_en;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];

   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && !empty_o;

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + AW'(1);
         if (rd_en) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/fsm_trace_monitor.sv
// Observes an FSM state bus, logs every transition into an event FIFO and
// raises sticky error flags. Optional dwell timeout: FSM_TRACE_MONITOR_TIMEOUT_EN.
module fsm_trace_monitor
   import fsm_trace_pkg::*;
#(
   parameter int W       = 8,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             obs_en,
   input  logic [W-1:0]     obs_val,
   input  logic             err_clr,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [W-1:0]     evt_prev,
   output logic [W-1:0]     evt_next,
   output logic [CNT_W-1:0] evt_dwell,
   output logic             evt_illegal,
   output logic             err_illegal,
   output logic             err_overflow,
`ifdef FSM_TRACE_MONITOR_TIMEOUT_EN
   output logic             err_timeout,
`endif
   output logic [7:0]       drop_cnt
);

   localparam int EW  = evt_w(W, CNT_W);
   localparam int ONX = off_next(CNT_W);
   localparam int OPV = off_prev(W, CNT_W);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DW_MAX = '1;

   state_e           state_q, state_d;
   logic [W-1:0]     cur_q, cur_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             ill_q, ill_d, ovf_q, ovf_d;
   logic [7:0]       drop_q, drop_d;
   logic             push, pop, drop, illegal;
   logic             fifo_full, fifo_empty;
   logic [EW-1:0]    wr_rec, rd_rec;
   logic [CW-1:0]    unused_count;

   assign push    = (state_q == S_TRACK) && obs_en && (obs_val != cur_q);
   assign illegal = push && !is_legal(32'(cur_q), 32'(obs_val), W);
   assign pop     = evt_valid && evt_ready;
   assign drop    = push && fifo_full && !pop;
   assign wr_rec  = {cur_q, obs_val, dwell_q, illegal};

   fsm_trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (wr_rec),
      .dout_o  (rd_rec),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (unused_count)
   );

   // Head fields are masked so stale storage never leaks out while empty.
   assign evt_valid   = !fifo_empty;
   assign evt_prev    = evt_valid ? rd_rec[OPV +: W]           : '0;
   assign evt_next    = evt_valid ? rd_rec[ONX +: W]           : '0;
   assign evt_dwell   = evt_valid ? rd_rec[OFF_DWELL +: CNT_W] : '0;
   assign evt_illegal = evt_valid && rd_rec[OFF_ILL];

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      dwell_d = dwell_q;
      case (state_q)
         S_IDLE: begin
            if (obs_en) begin
               state_d = S_TRACK;
               cur_d   = obs_val;
               dwell_d = CNT_W'(1);
            end
         end
         S_TRACK: begin
            if (!obs_en) begin
               state_d = S_IDLE;
            end else if (obs_val == cur_q) begin
               if (dwell_q != DW_MAX) dwell_d = dwell_q + CNT_W'(1);
            end else begin
               cur_d   = obs_val;
               dwell_d = CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sticky flags: a new error on the clear cycle wins.
   always_comb begin
      ill_d  = (ill_q && !err_clr) || illegal;
      ovf_d  = (ovf_q && !err_clr) || drop;
      drop_d = drop_q;
      if (err_clr)                         drop_d = drop ? 8'd1 : 8'd0;
      else if (drop && (drop_q != 8'hFF))  drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         dwell_q <= '0;
         ill_q   <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         dwell_q <= dwell_d;
         ill_q   <= ill_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   assign err_illegal  = ill_q;
   assign err_overflow = ovf_q;
   assign drop_cnt     = drop_q;

`ifdef FSM_TRACE_MONITOR_TIMEOUT_EN
   logic tmo_q, tmo_d, tmo_hit;

   // State code 0 is idle and may dwell indefinitely.
   assign tmo_hit = (state_q == S_TRACK) && (cur_q != '0) && (dwell_q >= CNT_W'(TIMEOUT));
   assign tmo_d   = (tmo_q && !err_clr) || tmo_hit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tmo_q <= 1'b0;
      else       tmo_q <= tmo_d;
   end

   assign err_timeout = tmo_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// Bench for fsm_trace_monitor: directed scenarios plus a randomized run
// against a queue-based transaction model.
module tb_fsm_trace_monitor;

   localparam int W = 8, DEPTH = 8, CNT_W = 16, TIMEOUT = 20;

   logic             clk = 1'b0, rstn = 1'b0, obs_en = 1'b0, err_clr = 1'b0, evt_ready = 1'b0;
   logic [W-1:0]     obs_val = '0;
   logic             evt_valid, evt_illegal, err_illegal, err_overflow;
   logic [W-1:0]     evt_prev, evt_next;
   logic [CNT_W-1:0] evt_dwell;
   logic [7:0]       drop_cnt;
`ifdef FSM_TRACE_MONITOR_TIMEOUT_EN
   logic             err_timeout;
`endif

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   fsm_trace_monitor #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .obs_en       (obs_en),
      .obs_val      (obs_val),
      .err_clr      (err_clr),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_prev     (evt_prev),
      .evt_next     (evt_next),
      .evt_dwell    (evt_dwell),
      .evt_illegal  (evt_illegal),
      .err_illegal  (err_illegal),
      .err_overflow (err_overflow),
`ifdef FSM_TRACE_MONITOR_TIMEOUT_EN
      .err_timeout  (err_timeout),
`endif
      .drop_cnt     (drop_cnt)
   );

   // Transaction-level model of the monitor.
   typedef struct {
      logic [7:0] p;
      logic [7:0] n;
      int         d;
      logic       ill;
   } ev_t;

   ev_t q[$];
   bit  m_trk, m_ill, m_ovf;
   int  m_cur, m_dwell, m_drop;

   task automatic model_reset();
      q.delete();
      m_trk = 0; m_ill = 0; m_ovf = 0;
      m_cur = 0; m_dwell = 0; m_drop = 0;
   endtask

   task automatic model_step();
      bit  do_pop, do_push, do_drop, ill;
      ev_t e;
      do_push = 0; do_drop = 0; ill = 0;
      e = '{p: 8'd0, n: 8'd0, d: 0, ill: 1'b0};
      if (!rstn) begin
         model_reset();
         return;
      end
      do_pop = (q.size() != 0) && evt_ready;
      if (!m_trk) begin
         if (obs_en) begin m_trk = 1; m_cur = int'(obs_val); m_dwell = 1; end
      end else if (!obs_en) begin
         m_trk = 0;
      end else if (int'(obs_val) == m_cur) begin
         if (m_dwell < 65535) m_dwell++;
      end else begin
         ill = !((int'(obs_val) == (m_cur + 1) % 256) || (obs_val == 8'd0));
         e.p = 8'(m_cur); e.n = obs_val; e.d = m_dwell; e.ill = ill;
         do_push = 1;
         m_cur = int'(obs_val); m_dwell = 1;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         if (q.size() < DEPTH) q.push_back(e);
         else do_drop = 1;
      end
      if (err_clr) begin m_ill = 0; m_ovf = 0; m_drop = 0; end
      if (ill) m_ill = 1;
      if (do_drop) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; obs_en = 1'b0; err_clr = 1'b0; evt_ready = 1'b0; obs_val = '0;
      model_reset();
      #12;
      tick();
      total++;
      if ({evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal} !== '0) begin
         bad++; $display("FAIL reset_evt got=%h want=0", {evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal});
      end
      total++;
      if ({err_illegal, err_overflow, drop_cnt} !== '0) begin
         bad++; $display("FAIL reset_err got=%h want=0", {err_illegal, err_overflow, drop_cnt});
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_legal_seq();
      evt_ready = 1'b1; obs_en = 1'b1; obs_val = 8'd0;
      repeat (5) tick();
      obs_val = 8'd1;
      tick();
      total++;
      if ({evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal} !== {1'b1, 8'd0, 8'd1, 16'd5, 1'b0}) begin
         bad++; $display("FAIL seq_ev01 got=%0d/%0d/%0d/%0d/%0d want=1/0/1/5/0",
                         evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal);
      end
      repeat (2) tick();
      obs_val = 8'd2;
      tick();
      total++;
      if ({evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal} !== {1'b1, 8'd1, 8'd2, 16'd3, 1'b0}) begin
         bad++; $display("FAIL seq_ev12 got=%0d/%0d/%0d/%0d/%0d want=1/1/2/3/0",
                         evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal);
      end
      total++;
      if (err_illegal !== 1'b0) begin bad++; $display("FAIL seq_noill got=%b want=0", err_illegal); end
   endtask

   task automatic test_illegal();
      obs_val = 8'd3; tick(); tick();
      obs_val = 8'd7; tick();
      total++;
      if ({evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal, err_illegal} !==
          {1'b1, 8'd3, 8'd7, 16'd2, 1'b1, 1'b1}) begin
         bad++; $display("FAIL ill_ev37 got=%0d/%0d/%0d/%0d/%0d err=%0d want=1/3/7/2/1 err=1",
                         evt_valid, evt_prev, evt_next, evt_dwell, evt_illegal, err_illegal);
      end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      total++;
      if (err_illegal !== 1'b0) begin bad++; $display("FAIL ill_clr got=%b want=0", err_illegal); end
      obs_val = 8'd0; tick();
      total++;
      if ({evt_valid, evt_next, evt_illegal, err_illegal} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL ill_to_idle got=%0d/%0d/%0d err=%0d want=1/0/0 err=0",
                         evt_valid, evt_next, evt_illegal, err_illegal);
      end
   endtask

   task automatic test_overflow();
      repeat (3) tick();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      evt_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin obs_val = 8'(i); tick(); end
      repeat (2) tick();
      total++;
      if ({drop_cnt, err_overflow} !== {8'd2, 1'b1}) begin
         bad++; $display("FAIL ovf_flags got drop=%0d ovf=%b want drop=2 ovf=1", drop_cnt, err_overflow);
      end
      total++;
      if ({evt_valid, evt_prev, evt_next} !== {1'b1, 8'd0, 8'd1}) begin
         bad++; $display("FAIL ovf_hold got=%0d/%0d/%0d want=1/0/1", evt_valid, evt_prev, evt_next);
      end
      evt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         total++;
         if ({evt_valid, evt_prev, evt_next, evt_illegal} !== {1'b1, 8'(k), 8'(k + 1), 1'b0}) begin
            bad++; $display("FAIL ovf_drain%0d got=%0d/%0d/%0d/%0d want=1/%0d/%0d/0",
                            k, evt_valid, evt_prev, evt_next, evt_illegal, k, k + 1);
         end
         tick();
      end
      total++;
      if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", evt_valid); end
   endtask

   task automatic test_full_pushpop();
      int n;
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      evt_ready = 1'b0;
      for (int i = 11; i <= 18; i++) begin obs_val = 8'(i); tick(); end
      obs_val = 8'd19; evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      total++;
      if ({drop_cnt, err_overflow} !== {8'd0, 1'b0}) begin
         bad++; $display("FAIL full_nodrop got drop=%0d ovf=%b want drop=0 ovf=0", drop_cnt, err_overflow);
      end
      total++;
      if ({evt_prev, evt_next} !== {8'd11, 8'd12}) begin
         bad++; $display("FAIL full_head got=%0d/%0d want=11/12", evt_prev, evt_next);
      end
      evt_ready = 1'b1; n = 0;
      while (evt_valid && n < 20) begin n++; tick(); end
      total++;
      if (n != 8) begin bad++; $display("FAIL full_count got=%0d want=8", n); end
   endtask

   task automatic test_reset_mid();
      evt_ready = 1'b0;
      for (int i = 20; i <= 22; i++) begin obs_val = 8'(i); tick(); end
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({evt_valid, evt_prev, evt_next, evt_dwell, err_illegal, err_overflow, drop_cnt} !== '0) begin
         bad++; $display("FAIL rst_mid got valid=%b prev=%0d next=%0d", evt_valid, evt_prev, evt_next);
      end
      model_reset();
      tick();
      rstn = 1'b1; obs_en = 1'b0;
      repeat (3) tick();
      obs_en = 1'b1;
      repeat (4) tick();
      total++;
      if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_noentry got=%b want=0", evt_valid); end
      obs_val = 8'd23; tick();
      total++;
      if ({evt_valid, evt_prev, evt_next, evt_dwell} !== {1'b1, 8'd22, 8'd23, 16'd4}) begin
         bad++; $display("FAIL rst_first got=%0d/%0d/%0d/%0d want=1/22/23/4",
                         evt_valid, evt_prev, evt_next, evt_dwell);
      end
      evt_ready = 1'b1; repeat (2) tick();
   endtask

`ifdef FSM_TRACE_MONITOR_TIMEOUT_EN
   task automatic test_timeout();
      evt_ready = 1'b1; obs_en = 1'b1;
      obs_val = 8'd3; tick();
      obs_val = 8'd4; tick();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      repeat (15) tick();
      total++;
      if (err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", err_timeout); end
      repeat (5) tick();
      total++;
      if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_set got=%b want=1", err_timeout); end
      obs_val = 8'd0; tick();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      repeat (50) tick();
      total++;
      if (err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b want=0", err_timeout); end
   endtask
`endif

   task automatic test_random();
      int r;
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         obs_en    = ($urandom_range(0, 19) != 0);
         evt_ready = ($urandom_range(0, 9) < 6);
         err_clr   = ($urandom_range(0, 29) == 0);
         r = int'($urandom_range(0, 9));
         if (r < 4)       obs_val = 8'(m_cur);
         else if (r < 7)  obs_val = 8'(m_cur + 1);
         else if (r == 7) obs_val = 8'd0;
         else             obs_val = 8'($urandom_range(0, 255));
         tick();
         total++;
         if (evt_valid !== (q.size() != 0)) begin
            bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, evt_valid, q.size() != 0);
         end
         if (q.size() != 0) begin
            total++;
            if ({evt_prev, evt_next, evt_dwell, evt_illegal} !== {q[0].p, q[0].n, 16'(q[0].d), q[0].ill}) begin
               bad++; $display("FAIL rnd_head c=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", c,
                               evt_prev, evt_next, evt_dwell, evt_illegal, q[0].p, q[0].n, q[0].d, q[0].ill);
            end
         end
         total++;
         if ({err_illegal, err_overflow, drop_cnt} !== {m_ill, m_ovf, 8'(m_drop)}) begin
            bad++; $display("FAIL rnd_err c=%0d got=%b/%b/%0d want=%b/%b/%0d", c,
                            err_illegal, err_overflow, drop_cnt, m_ill, m_ovf, m_drop);
         end
      end
      err_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_legal_seq();
      test_illegal();
      test_overflow();
      test_full_pushpop();
      test_reset_mid();
`ifdef FSM_TRACE_MONITOR_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
